// File: rtl/clk_monitor.sv
// Divided-clock monitor: synchronizes mon_clk into clk, strobes its edges, measures period and high time, and tracks lock / loss.
// Define CLK_MON_DUTY_EN to build the high-time counter and add the duty-cycle check to the good-period test.
module clk_monitor #(
    parameter int SYNC_STAGES = 2,
    parameter int CNT_W       = 16,
    parameter int EXP_PERIOD  = 11,
    parameter int TOL         = 1,
    parameter int LOCK_CNT    = 4,
    parameter int TIMEOUT     = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             mon_clk,
    output logic             rise_pulse,
    output logic             fall_pulse,
    output logic [CNT_W-1:0] period,
    output logic [CNT_W-1:0] high_time,
    output logic             meas_valid,
    output logic             locked,
    output logic             lost,
    output logic             err,
    output logic [7:0]       err_count
);
    typedef enum logic [1:0] {IDLE, MEASURE, LOCKED, LOST} state_t;

    localparam int               RUN_W     = $clog2(LOCK_CNT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;
    localparam logic [CNT_W-1:0] PER_MIN   = CNT_W'(EXP_PERIOD - TOL);
    localparam logic [CNT_W-1:0] PER_MAX   = CNT_W'(EXP_PERIOD + TOL);
    localparam logic [CNT_W-1:0] TIMEOUT_V = CNT_W'(TIMEOUT);
    localparam logic [RUN_W-1:0] RUN_LAST  = RUN_W'(LOCK_CNT - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   hist_q;
    logic                   rise_det_q;
    logic                   fall_det_q;

    state_t                 state_q;
    logic [RUN_W-1:0]       run_q;
    logic [CNT_W-1:0]       cyc_q;
    logic [CNT_W-1:0]       cyc_d;
    logic [CNT_W-1:0]       period_q;
    logic                   rise_q;
    logic                   fall_q;
    logic                   meas_valid_q;
    logic                   err_q;
    logic [7:0]             err_cnt_q;
    logic                   period_ok;
    logic                   timed_out;

    // Edge detection is registered once more so all downstream logic sees a clean one-cycle strobe.
    // NOTE: reset is synchronous here; every flop, synchronizer included, clears on the clk edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q     <= '0;
            hist_q     <= 1'b0;
            rise_det_q <= 1'b0;
            fall_det_q <= 1'b0;
        end else begin
            sync_q     <= {sync_q[SYNC_STAGES-2:0], mon_clk};
            hist_q     <= sync_q[SYNC_STAGES-1];
            rise_det_q <= sync_q[SYNC_STAGES-1] & ~hist_q;
            fall_det_q <= ~sync_q[SYNC_STAGES-1] & hist_q;
        end
    end

    // NOTE: give every always_comb output a default first so no path can infer a latch.
    always_comb begin
        cyc_d = cyc_q;
        if (rise_det_q) begin
            cyc_d = CNT_W'(1);
        end else if (cyc_q != CNT_MAX) begin
            cyc_d = cyc_q + 1'b1;
        end
    end

`ifdef CLK_MON_DUTY_EN
    localparam logic [CNT_W-1:0] HI_MIN = CNT_W'(EXP_PERIOD / 2 - TOL);
    localparam logic [CNT_W-1:0] HI_MAX = CNT_W'((EXP_PERIOD + 1) / 2 + TOL);

    logic [CNT_W-1:0] high_cnt_q;
    logic [CNT_W-1:0] high_cnt_d;
    logic [CNT_W-1:0] high_q;

    always_comb begin
        high_cnt_d = high_cnt_q;
        if (rise_det_q) begin
            high_cnt_d = CNT_W'(1);
        end else if (high_cnt_q != CNT_MAX) begin
            high_cnt_d = high_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            high_cnt_q <= '0;
            high_q     <= '0;
        end else begin
            high_cnt_q <= high_cnt_d;
            if (fall_det_q) begin
                high_q <= high_cnt_q;
            end
        end
    end

    assign high_time = high_q;
`else
    assign high_time = '0;
`endif

    // A saturated count means the period overflowed, so it is never accepted even if the window is wide.
    always_comb begin
        period_ok = (cyc_q >= PER_MIN) && (cyc_q <= PER_MAX) && (cyc_q != CNT_MAX);
`ifdef CLK_MON_DUTY_EN
        period_ok = period_ok && (high_q >= HI_MIN) && (high_q <= HI_MAX);
`endif
    end

    assign timed_out = (cyc_q >= TIMEOUT_V);

    // Rise is tested before timeout in each state so a same-cycle rise always wins.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            run_q        <= '0;
            cyc_q        <= '0;
            period_q     <= '0;
            rise_q       <= 1'b0;
            fall_q       <= 1'b0;
            meas_valid_q <= 1'b0;
            err_q        <= 1'b0;
            err_cnt_q    <= '0;
        end else begin
            cyc_q        <= cyc_d;
            rise_q       <= rise_det_q;
            fall_q       <= fall_det_q;
            meas_valid_q <= 1'b0;
            err_q        <= 1'b0;
            case (state_q)
                IDLE, LOST: begin
                    if (rise_det_q) begin
                        state_q <= MEASURE;
                        run_q   <= '0;
                    end
                end
                MEASURE: begin
                    if (rise_det_q) begin
                        period_q     <= cyc_q;
                        meas_valid_q <= 1'b1;
                        if (!period_ok) begin
                            run_q <= '0;
                        end else if (run_q == RUN_LAST) begin
                            run_q   <= '0;
                            state_q <= LOCKED;
                        end else begin
                            run_q <= run_q + 1'b1;
                        end
                    end else if (timed_out) begin
                        run_q   <= '0;
                        state_q <= LOST;
                    end
                end
                LOCKED: begin
                    if (rise_det_q) begin
                        period_q     <= cyc_q;
                        meas_valid_q <= 1'b1;
                        if (!period_ok) begin
                            err_q   <= 1'b1;
                            run_q   <= '0;
                            state_q <= MEASURE;
                            if (err_cnt_q != 8'hFF) begin
                                err_cnt_q <= err_cnt_q + 1'b1;
                            end
                        end
                    end else if (timed_out) begin
                        run_q   <= '0;
                        state_q <= LOST;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign rise_pulse = rise_q;
    assign fall_pulse = fall_q;
    assign period     = period_q;
    assign meas_valid = meas_valid_q;
    assign locked     = (state_q == LOCKED);
    assign lost       = (state_q == LOST);
    assign err        = err_q;
    assign err_count  = err_cnt_q;

endmodule

// File: tb/tb_clk_monitor.sv
// Self-checking bench for clk_monitor: table-driven mon_clk periods with a scoreboard popped on every rise_pulse,
// plus hand sequences for loss-of-clock, mid-measurement reset, glitch latency and (with CLK_MON_DUTY_EN) duty rejection.
module tb_clk_monitor;
    localparam int CNT_W = 16;

    logic             clk = 1'b0;
    logic             rst;
    logic             mon_clk;
    logic             rise_pulse;
    logic             fall_pulse;
    logic [CNT_W-1:0] period;
    logic [CNT_W-1:0] high_time;
    logic             meas_valid;
    logic             locked;
    logic             lost;
    logic             err;
    logic [7:0]       err_count;

    clk_monitor dut (
        .clk        (clk),
        .rst        (rst),
        .mon_clk    (mon_clk),
        .rise_pulse (rise_pulse),
        .fall_pulse (fall_pulse),
        .period     (period),
        .high_time  (high_time),
        .meas_valid (meas_valid),
        .locked     (locked),
        .lost       (lost),
        .err        (err),
        .err_count  (err_count)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int   hi;
        int   lo;
        logic mv;
        int   per;
        logic lck;
        logic er;
        int   ecnt;
        logic lst;
    } vec_t;

    typedef struct {
        logic mv;
        int   per;
        logic lck;
        logic er;
        int   ecnt;
        logic lst;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;
    int   n_cmp = 0;
    int   n_err = 0;
    int   last_rise_cyc = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push_exp(input vec_t v);
        exp_t e;
        e = '{v.mv, v.per, v.lck, v.er, v.ecnt, v.lst};
        sb_q.push_back(e);
    endtask

    task automatic drive_cycle(input vec_t v);
        push_exp(v);
        mon_clk = 1'b1;
        tick(v.hi);
        mon_clk = 1'b0;
        tick(v.lo);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_rise_pulse"}, 32'(rise_pulse), 0);
        check({tag, "_fall_pulse"}, 32'(fall_pulse), 0);
        check({tag, "_period"},     32'(period), 0);
        check({tag, "_high_time"},  32'(high_time), 0);
        check({tag, "_meas_valid"}, 32'(meas_valid), 0);
        check({tag, "_locked"},     32'(locked), 0);
        check({tag, "_lost"},       32'(lost), 0);
        check({tag, "_err"},        32'(err), 0);
        check({tag, "_err_count"},  32'(err_count), 0);
    endtask

    // Scoreboard: every rise_pulse consumes one expectation; strobes never appear without a rise.
    always @(negedge clk) begin
        if (rise_pulse === 1'b1) begin
            last_rise_cyc = cyc;
            if (sb_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_rise: rise_pulse with empty scoreboard (t=%0t)", $time);
            end else begin
                mon_e = sb_q.pop_front();
                check("sb_meas_valid", 32'(meas_valid), 32'(mon_e.mv));
                check("sb_period",     32'(period), mon_e.per);
                check("sb_locked",     32'(locked), 32'(mon_e.lck));
                check("sb_err",        32'(err), 32'(mon_e.er));
                check("sb_err_count",  32'(err_count), mon_e.ecnt);
                check("sb_lost",       32'(lost), 32'(mon_e.lst));
            end
        end else begin
            check("meas_valid_without_rise", 32'(meas_valid), 0);
            check("err_without_rise",        32'(err), 0);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    vec_t tbl[12];
    vec_t v;
    bit   seen;
    int   e0;
    int   rise_c;
    int   fall_c;

    initial begin
        // hi, lo, meas_valid, period, locked, err, err_count, lost -- expectations at each rise
        tbl = '{
            '{5, 6, 1'b0,  0, 1'b0, 1'b0, 0, 1'b0},
            '{6, 5, 1'b1, 11, 1'b0, 1'b0, 0, 1'b0},
            '{5, 6, 1'b1, 11, 1'b0, 1'b0, 0, 1'b0},
            '{6, 5, 1'b1, 11, 1'b0, 1'b0, 0, 1'b0},
            '{5, 6, 1'b1, 11, 1'b1, 1'b0, 0, 1'b0},
            '{6, 8, 1'b1, 11, 1'b1, 1'b0, 0, 1'b0},
            '{5, 6, 1'b1, 14, 1'b0, 1'b1, 1, 1'b0},
            '{6, 5, 1'b1, 11, 1'b0, 1'b0, 1, 1'b0},
            '{5, 6, 1'b1, 11, 1'b0, 1'b0, 1, 1'b0},
            '{6, 5, 1'b1, 11, 1'b0, 1'b0, 1, 1'b0},
            '{5, 6, 1'b1, 11, 1'b1, 1'b0, 1, 1'b0},
            '{5, 6, 1'b1, 11, 1'b1, 1'b0, 1, 1'b0}
        };

        mon_clk = 1'b0;
        rst     = 1'b1;
        tick(3);
        check_all_zero("reset");
        rst = 1'b0;
        tick(2);

        // Lock, one long period while locked, relock.
        for (int i = 0; i < 12; i++) begin
            drive_cycle(tbl[i]);
        end
        tick(4);
        check("sb_drain_main", sb_q.size(), 0);
`ifndef CLK_MON_DUTY_EN
        check("high_time_tied_off", 32'(high_time), 0);
`endif

        // Stop mon_clk while locked: lost must follow the last counter load by TIMEOUT cycles.
        seen = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (lost === 1'b1) begin
                seen = 1'b1;
                break;
            end
        end
        check("lost_asserted", 32'(seen), 1);
        check("lost_latency", cyc - last_rise_cyc, 64);
        check("locked_when_lost", 32'(locked), 0);
        @(posedge clk);
        #1;

        // Restart: first rise leaves LOST without publishing, then three good periods.
        drive_cycle('{5, 6, 1'b0, 11, 1'b0, 1'b0, 1, 1'b0});
        drive_cycle('{6, 5, 1'b1, 11, 1'b0, 1'b0, 1, 1'b0});
        drive_cycle('{5, 6, 1'b1, 11, 1'b0, 1'b0, 1, 1'b0});
        push_exp('{6, 5, 1'b1, 11, 1'b0, 1'b0, 1, 1'b0});
        mon_clk = 1'b1;
        tick(6);
        mon_clk = 1'b0;
        tick(2);
        check("sb_drain_restart", sb_q.size(), 0);

        // Reset mid-MEASURE with three good periods counted.
        rst = 1'b1;
        tick(1);
        check_all_zero("mid_reset");
        rst = 1'b0;
        tick(3);

        // A fresh first rise plus four good periods are needed to lock again.
        for (int i = 0; i < 5; i++) begin
            v = '{(i % 2 == 0) ? 5 : 6, (i % 2 == 0) ? 6 : 5, i > 0, (i > 0) ? 11 : 0, i == 4, 1'b0, 0, 1'b0};
            drive_cycle(v);
        end
        tick(4);
        check("sb_drain_relock", sb_q.size(), 0);
        check("relocked_level", 32'(locked), 1);

        // One-cycle glitch: both strobes appear SYNC_STAGES+1 cycles after their samples.
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
        tick(3);
        e0 = cyc;
        push_exp('{1, 1, 1'b0, 0, 1'b0, 1'b0, 0, 1'b0});
        mon_clk = 1'b1;
        tick(1);
        mon_clk = 1'b0;
        rise_c = -1;
        fall_c = -1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (rise_pulse === 1'b1 && rise_c < 0) rise_c = cyc;
            if (fall_pulse === 1'b1 && fall_c < 0) fall_c = cyc;
        end
        check("glitch_rise_latency", rise_c - (e0 + 1), 3);
        check("glitch_fall_latency", fall_c - (e0 + 2), 3);
        check("sb_drain_glitch", sb_q.size(), 0);
        @(posedge clk);
        #1;

`ifdef CLK_MON_DUTY_EN
        // Period 11 with only 2 high: every period fails the duty window, so no lock.
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
        tick(3);
        for (int i = 0; i < 7; i++) begin
            v = '{2, 9, i > 0, (i > 0) ? 11 : 0, 1'b0, 1'b0, 0, 1'b0};
            drive_cycle(v);
        end
        tick(4);
        check("duty_high_time", 32'(high_time), 2);
        check("duty_never_locked", 32'(locked), 0);
        check("sb_drain_duty", sb_q.size(), 0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
